// File: rtl/obc1_oam_dump_pkg.sv
// Shared constants and FSM state type for the OBC1 OAM dump streamer.
package obc1_oam_dump_pkg;

  localparam int OBC1_LOW_BYTES  = 512;
  localparam int OBC1_HIGH_BYTES = 32;
  localparam int OBC1_DUMP_LEN   = OBC1_LOW_BYTES + OBC1_HIGH_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/obc1_stream_fifo.sv
// Two-entry byte+last FIFO with valid/ready on both sides and a synchronous flush.
module obc1_stream_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] count
);

  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       push;
  logic       pop;
  logic [8:0] head;

  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [8:0] entry_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= 9'd0;
        end else if (push && !flush && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= {in_last, in_data};
        end
      end
    end
  endgenerate

  assign head     = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;
  assign out_data = head[7:0];
  // Gate last with valid so a stale entry never shows a last flag.
  assign out_last = out_valid && head[8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/obc1_oam_dump.sv
// Streams one OAM bank (low table then high table) out of two 1-cycle-latency RAMs.
module obc1_oam_dump
  import obc1_oam_dump_pkg::*;
#(
  parameter int DUMP_LEN = OBC1_DUMP_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       bank,
  output logic [9:0] low_addr,
  input  logic [7:0] low_data,
  output logic [5:0] high_addr,
  input  logic [7:0] high_data,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       dout_last,
  output logic       busy,
  output logic       done
);

  localparam logic [9:0] LAST_IDX  = 10'(DUMP_LEN - 1);
  localparam logic [9:0] HIGH_BASE = 10'(OBC1_LOW_BYTES);

  state_t     state_reg, state_next;
  logic [9:0] idx_reg;
  logic       bank_reg;
  logic       inflight_reg;
  logic       src_high_reg;
  logic       last_rd_reg;
  logic       done_reg;

  logic       accept;
  logic       issue;
  logic       flush;
  logic       done_next;
  logic       pop;
  logic       fifo_in_ready;
  logic       fifo_push;
  logic [1:0] fifo_count;
  logic [2:0] occupancy;
  logic [7:0] rd_byte;

  // Addresses come straight from the next-read index, so they sit still in IDLE.
  assign low_addr  = {bank_reg, idx_reg[8:0]};
  assign high_addr = {bank_reg, idx_reg[4:0]};

  assign pop       = dout_valid && dout_ready;
  // Occupancy after this cycle's pop, so a steady consumer keeps one read per cycle.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};
  assign rd_byte   = src_high_reg ? high_data : low_data;
  assign fifo_push = inflight_reg && fifo_in_ready;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    issue      = 1'b0;
    flush      = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start && !abort) begin
          state_next = ST_RUN;
          accept     = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next = ST_IDLE;
          flush      = 1'b1;
        end else if (occupancy < 3'd2) begin
          issue = 1'b1;
          if (idx_reg == LAST_IDX) state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_next = ST_IDLE;
          flush      = 1'b1;
        end else if (pop && dout_last) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        flush      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg      <= 10'd0;
      bank_reg     <= 1'b0;
      inflight_reg <= 1'b0;
      src_high_reg <= 1'b0;
      last_rd_reg  <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg     <= done_next;
      inflight_reg <= issue;
      if (accept) begin
        idx_reg  <= 10'd0;
        bank_reg <= bank;
      end else if (issue && (idx_reg != LAST_IDX)) begin
        idx_reg <= idx_reg + 10'd1;
      end
      // Source select and last tag travel with the read to line up with RAM latency.
      if (issue) begin
        src_high_reg <= (idx_reg >= HIGH_BASE);
        last_rd_reg  <= (idx_reg == LAST_IDX);
      end
    end
  end

  obc1_stream_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (rd_byte),
    .in_last   (last_rd_reg),
    .in_valid  (fifo_push),
    .in_ready  (fifo_in_ready),
    .out_data  (dout),
    .out_last  (dout_last),
    .out_valid (dout_valid),
    .out_ready (dout_ready),
    .count     (fifo_count)
  );

endmodule
